// File: rtl/wb_sync_sequencer_if.sv
// Bus bundle between the instruction sequencer and the datapath.
// The master side is the sequencer: it reads control requests and
// write-back acks, and drives stage strobes, PC and status.
interface wb_sync_sequencer_if #(
  parameter int WORD = 32,
  parameter int N_WB = 6
);
  // Requests and handshakes coming from the datapath / core top
  logic            start;
  logic            halt;
  logic [N_WB-1:0] wb_req;
  logic [N_WB-1:0] wb_ack;
  logic            jump;
  logic            rjump;
  logic [WORD-1:0] jump_loc;
  logic [WORD-1:0] jump_inc;

  // Strobes and status produced by the sequencer
  logic            fetch_tr;
  logic            reg_tr;
  logic            dne_tr;
  logic [N_WB-1:0] wb_tr;
  logic [WORD-1:0] pc;
  logic            busy;
  logic [WORD-1:0] retired;
  logic            err_timeout;

  modport master (
    input  start, halt, wb_req, wb_ack, jump, rjump, jump_loc, jump_inc,
    output fetch_tr, reg_tr, dne_tr, wb_tr, pc, busy, retired, err_timeout
  );

  modport slave (
    output start, halt, wb_req, wb_ack, jump, rjump, jump_loc, jump_inc,
    input  fetch_tr, reg_tr, dne_tr, wb_tr, pc, busy, retired, err_timeout
  );
endinterface

// File: rtl/wb_sync_sequencer.sv
// Instruction-cycle sequencer for the graph-traversal core.
// Walks FETCH -> DECODE -> EXEC -> CHECK, then optionally WB where the
// write-back channels are acknowledged and the PC write-back (jump or
// relative jump) is applied. A WB phase that stalls for TIMEOUT cycles is
// aborted and latches a sticky error that blocks further starts.
module wb_sync_sequencer #(
  parameter int WORD        = 32,
  parameter int N_WB        = 6,
  parameter int INSTR_WORDS = 3,
  parameter int TIMEOUT     = 15
) (
  input logic                 clk,
  input logic                 rst_n,
  wb_sync_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_CHECK  = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]          TMAX = TW'(TIMEOUT);
  localparam logic [WORD-1:0]        IW   = WORD'(INSTR_WORDS);
  localparam logic signed [WORD-1:0] IW_S = WORD'(INSTR_WORDS);

  state_t          state_q;
  logic            fetch_tr_q;
  logic            reg_tr_q;
  logic            dne_tr_q;
  logic [N_WB-1:0] pending_q;
  logic [N_WB-1:0] pending_d;
  logic [WORD-1:0] pc_q;
  logic [WORD-1:0] pc_tgt_q;
  logic            pc_pend_q;
  logic [WORD-1:0] retired_q;
  logic [TW-1:0]   timer_q;
  logic [TW-1:0]   timer_d;
  logic            err_q;

  // Absolute jump target: instruction index scaled to memory words.
  function automatic logic [WORD-1:0] abs_target(input logic [WORD-1:0] loc);
    return loc * IW;
  endfunction

  // Relative target. pc has already stepped past the current instruction
  // in DECODE, so one instruction is taken back. Two's-complement wrap
  // makes the signed offset work on the unsigned PC.
  function automatic logic [WORD-1:0] rel_target(input logic [WORD-1:0]        cur,
                                                 input logic signed [WORD-1:0] inc);
    logic signed [WORD-1:0] step;
    step = inc * IW_S;
    return cur + WORD'(step) - IW;
  endfunction

  // Pending mask and WB timer as they would stand after this cycle's acks.
  always_comb begin
    pending_d = pending_q & ~bus.wb_ack;
    timer_d   = timer_q + TW'(1);
  end

  // Sequencer FSM with registered stage strobes and all architectural state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_tr_q <= 1'b0;
      reg_tr_q   <= 1'b0;
      dne_tr_q   <= 1'b0;
      pending_q  <= '0;
      pc_q       <= '0;
      pc_tgt_q   <= '0;
      pc_pend_q  <= 1'b0;
      retired_q  <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      fetch_tr_q <= 1'b0;
      reg_tr_q   <= 1'b0;
      dne_tr_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start && !err_q) begin
            state_q    <= S_FETCH;
            fetch_tr_q <= 1'b1;
          end
        end
        S_FETCH: begin
          state_q  <= S_DECODE;
          reg_tr_q <= 1'b1;
        end
        S_DECODE: begin
          state_q  <= S_EXEC;
          dne_tr_q <= 1'b1;
          pc_q     <= pc_q + IW;
        end
        S_EXEC: begin
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          // Acks arriving together with the CHECK-cycle strobe count already.
          pending_q <= bus.wb_req & ~bus.wb_ack;
          pc_pend_q <= bus.jump | bus.rjump;
          pc_tgt_q  <= bus.jump ? abs_target(bus.jump_loc)
                                : rel_target(pc_q, signed'(bus.jump_inc));
          timer_q   <= '0;
          if ((bus.wb_req == '0) && !bus.jump && !bus.rjump) begin
            retired_q <= retired_q + WORD'(1);
            if (bus.halt) begin
              state_q <= S_IDLE;
            end else begin
              state_q    <= S_FETCH;
              fetch_tr_q <= 1'b1;
            end
          end else begin
            state_q <= S_WB;
          end
        end
        S_WB: begin
          // PC write-back always lands in the first WB cycle.
          pc_pend_q <= 1'b0;
          if (pc_pend_q) begin
            pc_q <= pc_tgt_q;
          end
          pending_q <= pending_d;
          timer_q   <= timer_d;
          if (pending_d == '0) begin
            retired_q <= retired_q + WORD'(1);
            if (bus.halt) begin
              state_q <= S_IDLE;
            end else begin
              state_q    <= S_FETCH;
              fetch_tr_q <= 1'b1;
            end
          end else if (timer_d == TMAX) begin
            err_q     <= 1'b1;
            pending_q <= '0;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Write-back strobes mirror the requests during CHECK, the only cycle
  // in which the requests are meaningful.
  assign bus.wb_tr       = (state_q == S_CHECK) ? bus.wb_req : '0;
  assign bus.fetch_tr    = fetch_tr_q;
  assign bus.reg_tr      = reg_tr_q;
  assign bus.dne_tr      = dne_tr_q;
  assign bus.pc          = pc_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.retired     = retired_q;
  assign bus.err_timeout = err_q;

endmodule
